arrow_scheduler: RTL and testbench

- Sequences a note chart into a fixed pool of arrow sprite slots for the rhythm-game display.
- Reads chart entries from a synchronous ROM, waits the encoded frame delta, then allocates a free slot and drives that slot's valid/direction/speed/inversed to one arrow sprite instance.
- Tracks each slot's age in frames and retires slots on a hit or on expiry (miss).
- Sits between the chart ROM / input judge and the bank of arrow renderers.

---
 rtl/arrow_scheduler_if.sv | 35 +++
 rtl/arrow_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_arrow_scheduler.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arrow_scheduler_if.sv
// -----------------------------------------------------------------------------
// arrow_scheduler_if
//
// Bus bundle between the arrow scheduler, the chart ROM and the input judge.
//
//   chart_addr_out  scheduler -> ROM    chart ROM address
//   chart_data_in   ROM -> scheduler    chart entry, registered inside the ROM
//   hit_in          judge -> scheduler  one-cycle hit strobe
//   hit_dir_in      judge -> scheduler  direction of the hit
//
// The scheduler connects through the master modport. The ROM / judge side
// (or a testbench standing in for them) uses the slave modport.
// -----------------------------------------------------------------------------
interface arrow_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] chart_addr_out;
    logic [15:0]       chart_data_in;
    logic              hit_in;
    logic [1:0]        hit_dir_in;

    modport master (
        output chart_addr_out,
        input  chart_data_in,
        input  hit_in,
        input  hit_dir_in
    );

    modport slave (
        input  chart_addr_out,
        output chart_data_in,
        output hit_in,
        output hit_dir_in
    );
endinterface

// File: rtl/arrow_scheduler.sv
// -----------------------------------------------------------------------------
// arrow_scheduler
//
// Plays a note chart into a fixed pool of arrow sprite slots. Chart entries
// are read from a synchronous ROM, each entry waits its frame delta, then takes
// the lowest free slot. Slots age once per frame and are retired either by a
// matching hit from the input judge or by expiry after LIFETIME frames.
//
// Ports:
//   clk                 system / pixel clock
//   rst_in              synchronous active-high reset
//   hcount_in/vcount_in current pixel position, used to derive one tick per frame
//   start_in            one-cycle pulse, starts playback at chart address 0
//   bus                 chart ROM address/data and hit strobe (master modport)
//   slot_valid_out      per-slot valid, one bit per slot
//   slot_dir_out        per-slot direction, slot i at [2i+1:2i]
//   slot_speed_out      per-slot speed, slot i at [3i+2:3i]
//   slot_inv_out        per-slot inversed flag
//   busy_out            high while the chart is being played
//   done_out            high after the end of the chart until the next start
//   hit_pulse_out       one-cycle pulse, a slot was retired by a hit
//   miss_pulse_out      one-cycle pulse, at least one slot expired
//   overflow_pulse_out  one-cycle pulse, a note was dropped (no free slot)
//
// Chart entry fields: [15:8] frame delta, [7:6] direction, [5:3] speed,
// [2] inversed, [1] end marker, [0] reserved.
// -----------------------------------------------------------------------------
module arrow_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 8,
    parameter int LIFETIME  = 180,
    parameter int HIT_LO    = 150,
    parameter int HIT_HI    = 175
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   start_in,
    arrow_scheduler_if.master      bus,
    output logic [NUM_SLOTS-1:0]   slot_valid_out,
    output logic [2*NUM_SLOTS-1:0] slot_dir_out,
    output logic [3*NUM_SLOTS-1:0] slot_speed_out,
    output logic [NUM_SLOTS-1:0]   slot_inv_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   hit_pulse_out,
    output logic                   miss_pulse_out,
    output logic                   overflow_pulse_out
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // Ages are 8-bit; bring the integer thresholds to the same width once.
    localparam logic [7:0] AGE_LAST = 8'(LIFETIME - 1);
    localparam logic [7:0] AGE_LO   = 8'(HIT_LO);
    localparam logic [7:0] AGE_HI   = 8'(HIT_HI);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_SPAWN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // -------------------------------------------------------------------------
    // Playback state
    // -------------------------------------------------------------------------
    logic [2:0]        state;
    logic [ADDR_W-1:0] chart_addr;
    logic              fetch_wait;   // set in the first FETCH cycle
    logic [7:0]        delta_cnt;
    logic [1:0]        note_dir;
    logic [2:0]        note_speed;
    logic              note_inv;

    // -------------------------------------------------------------------------
    // Slot register file
    // -------------------------------------------------------------------------
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [1:0]           slot_dir   [NUM_SLOTS];
    logic [2:0]           slot_speed [NUM_SLOTS];
    logic                 slot_inv   [NUM_SLOTS];
    logic [7:0]           slot_age   [NUM_SLOTS];

    // -------------------------------------------------------------------------
    // Frame tick: rising edge of the (0,0) pixel position. Comparing against
    // the registered copy makes a multi-cycle (0,0) dwell count only once.
    // -------------------------------------------------------------------------
    logic at_origin;
    logic at_origin_q;
    logic frame_tick;

    assign at_origin  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign frame_tick = at_origin && !at_origin_q;

    always_ff @(posedge clk) begin
        // NOTE: clocked state is always written with <= so every flop in the
        // design samples pre-edge values, independent of block ordering.
        if (rst_in) begin
            at_origin_q <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
        end
    end

    // -------------------------------------------------------------------------
    // Hit selection: oldest matching slot inside the age window, ties to the
    // lowest index (strict '>' keeps the earlier winner on equal ages).
    // -------------------------------------------------------------------------
    logic             hit_found;
    logic [IDX_W-1:0] hit_idx;
    logic [7:0]       hit_best_age;
    logic [NUM_SLOTS-1:0] hit_mask;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit_found    = 1'b0;
        hit_idx      = '0;
        hit_best_age = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.hit_in && slot_valid[i] && (slot_dir[i] == bus.hit_dir_in) &&
                (slot_age[i] >= AGE_LO) && (slot_age[i] <= AGE_HI)) begin
                if (!hit_found || (slot_age[i] > hit_best_age)) begin
                    hit_found    = 1'b1;
                    hit_idx      = IDX_W'(i);
                    hit_best_age = slot_age[i];
                end
            end
        end
    end

    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_mask[i] = hit_found && (hit_idx == IDX_W'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Expiry: a live slot at its last age when a frame ends. A slot that is
    // also being hit this cycle counts as a hit only.
    // -------------------------------------------------------------------------
    logic [NUM_SLOTS-1:0] expire_mask;

    always_comb begin
        expire_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            expire_mask[i] = frame_tick && slot_valid[i] && (slot_age[i] == AGE_LAST)
                             && !hit_mask[i];
        end
    end

    // -------------------------------------------------------------------------
    // Allocation: lowest-index slot whose valid is low right now. A slot being
    // retired this cycle still has valid high, so it is never reused in the
    // same cycle and the renderer always sees valid low for at least a cycle.
    // -------------------------------------------------------------------------
    logic             alloc_found;
    logic [IDX_W-1:0] alloc_idx;

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    logic spawn_now;
    assign spawn_now = (state == S_SPAWN);

    // -------------------------------------------------------------------------
    // Playback FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= S_IDLE;
            chart_addr <= '0;
            fetch_wait <= 1'b0;
            delta_cnt  <= '0;
            note_dir   <= '0;
            note_speed <= '0;
            note_inv   <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        chart_addr <= '0;
                        fetch_wait <= 1'b0;
                        done_out   <= 1'b0;
                        state      <= S_FETCH;
                    end
                end

                // The ROM registers the address once, so the entry for a new
                // address is stable in the second FETCH cycle.
                S_FETCH: begin
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait <= 1'b0;
                        if (bus.chart_data_in[1]) begin
                            done_out <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            delta_cnt  <= bus.chart_data_in[15:8];
                            note_dir   <= bus.chart_data_in[7:6];
                            note_speed <= bus.chart_data_in[5:3];
                            note_inv   <= bus.chart_data_in[2];
                            state      <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (delta_cnt == 8'd0) begin
                        state <= S_SPAWN;
                    end else if (frame_tick) begin
                        delta_cnt <= delta_cnt - 8'd1;
                    end
                end

                // The slot write itself happens in the slot block below.
                S_SPAWN: begin
                    if (chart_addr == {ADDR_W{1'b1}}) begin
                        done_out <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        chart_addr <= chart_addr + ADDR_W'(1);
                        state      <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.chart_addr_out = chart_addr;
    assign busy_out = (state == S_FETCH) || (state == S_HOLD) || (state == S_SPAWN);

    // -------------------------------------------------------------------------
    // Slot update and event pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            // NOTE: the slot file is a handful of flops, not a RAM, so it takes
            // the reset; a mid-playback reset must blank every arrow at once.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_valid[i] <= 1'b0;
                slot_dir[i]   <= '0;
                slot_speed[i] <= '0;
                slot_inv[i]   <= 1'b0;
                slot_age[i]   <= '0;
            end
            hit_pulse_out      <= 1'b0;
            miss_pulse_out     <= 1'b0;
            overflow_pulse_out <= 1'b0;
        end else begin
            hit_pulse_out      <= hit_found;
            miss_pulse_out     <= |expire_mask;
            overflow_pulse_out <= spawn_now && !alloc_found;

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (hit_mask[i] || expire_mask[i]) begin
                    slot_valid[i] <= 1'b0;
                    slot_dir[i]   <= '0;
                    slot_speed[i] <= '0;
                    slot_inv[i]   <= 1'b0;
                    slot_age[i]   <= '0;
                end else if (spawn_now && alloc_found && (alloc_idx == IDX_W'(i))) begin
                    slot_valid[i] <= 1'b1;
                    slot_dir[i]   <= note_dir;
                    slot_speed[i] <= note_speed;
                    slot_inv[i]   <= note_inv;
                    slot_age[i]   <= '0;
                end else if (frame_tick && slot_valid[i]) begin
                    slot_age[i] <= slot_age[i] + 8'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Flatten the slot file onto the renderer bus
    // -------------------------------------------------------------------------
    always_comb begin
        slot_valid_out = slot_valid;
        slot_dir_out   = '0;
        slot_speed_out = '0;
        slot_inv_out   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_dir_out[2*i +: 2]   = slot_dir[i];
            slot_speed_out[3*i +: 3] = slot_speed[i];
            slot_inv_out[i]          = slot_inv[i];
        end
    end

endmodule

// File: tb/tb_arrow_scheduler.sv
// -----------------------------------------------------------------------------
// tb_arrow_scheduler
//
// Directed scenarios followed by a randomized run, all checked against a
// note/slot reference model: the chart is walked entry by entry, frame ticks
// count down the head note's delta, spawns take the lowest free slot, hits
// pick the oldest in-window slot of the hit direction, expiries retire slots
// at their last age. Every stimulus step is followed by enough idle cycles for
// the design to settle, then the whole visible state is compared.
// HIT_HI is raised to LIFETIME-1 so a hit can land on the expiring frame.
// -----------------------------------------------------------------------------
module tb_arrow_scheduler;

    localparam int NS   = 4;
    localparam int AW   = 8;
    localparam int LIFE = 180;
    localparam int HLO  = 150;
    localparam int HHI  = 179;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst_in;
    logic [10:0]      hcount_in;
    logic [9:0]       vcount_in;
    logic             start_in;
    logic [NS-1:0]    slot_valid_out;
    logic [2*NS-1:0]  slot_dir_out;
    logic [3*NS-1:0]  slot_speed_out;
    logic [NS-1:0]    slot_inv_out;
    logic             busy_out;
    logic             done_out;
    logic             hit_pulse_out;
    logic             miss_pulse_out;
    logic             overflow_pulse_out;

    arrow_scheduler_if #(.ADDR_W(AW)) bus ();

    arrow_scheduler #(
        .NUM_SLOTS(NS), .ADDR_W(AW), .LIFETIME(LIFE), .HIT_LO(HLO), .HIT_HI(HHI)
    ) dut (
        .clk                (clk),
        .rst_in             (rst_in),
        .hcount_in          (hcount_in),
        .vcount_in          (vcount_in),
        .start_in           (start_in),
        .bus                (bus),
        .slot_valid_out     (slot_valid_out),
        .slot_dir_out       (slot_dir_out),
        .slot_speed_out     (slot_speed_out),
        .slot_inv_out       (slot_inv_out),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .hit_pulse_out      (hit_pulse_out),
        .miss_pulse_out     (miss_pulse_out),
        .overflow_pulse_out (overflow_pulse_out)
    );

    always #5 clk = ~clk;

    // Chart ROM: one register stage, data follows the address by one edge.
    logic [15:0] rom [DEPTH];
    always_ff @(posedge clk) bus.chart_data_in <= rom[bus.chart_addr_out];

    // Pulse monitors: count high cycles, so a stretched pulse is also caught.
    int hit_seen  = 0;
    int miss_seen = 0;
    int ovf_seen  = 0;
    always @(negedge clk) begin
        if (hit_pulse_out)      hit_seen  <= hit_seen + 1;
        if (miss_pulse_out)     miss_seen <= miss_seen + 1;
        if (overflow_pulse_out) ovf_seen  <= ovf_seen + 1;
    end

    // ---------------------------------------------------------------- model
    typedef struct {
        bit       v;
        bit [1:0] d;
        bit [2:0] s;
        bit       i;
        int       age;
    } slot_t;

    slot_t m [NS];
    int    m_ptr, m_rem;
    bit    m_active, m_started;
    int    exp_hit = 0, exp_miss = 0, exp_ovf = 0;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void m_clear(int k);
        m[k].v = 1'b0; m[k].d = '0; m[k].s = '0; m[k].i = 1'b0; m[k].age = 0;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < NS; k++) m_clear(k);
        m_active  = 1'b0;
        m_started = 1'b0;
    endfunction

    function automatic void m_load_head();
        logic [15:0] e;
        if (m_ptr >= DEPTH) begin
            m_active = 1'b0;
        end else begin
            e = rom[m_ptr];
            if (e[1]) m_active = 1'b0;
            else      m_rem = int'(e[15:8]);
        end
    endfunction

    // Spawn every note whose wait has run out, chaining through chords.
    function automatic void m_spawn_ready();
        logic [15:0] e;
        int f;
        while (m_active && m_rem == 0) begin
            e = rom[m_ptr];
            f = -1;
            for (int k = 0; k < NS; k++) if (!m[k].v && f < 0) f = k;
            if (f < 0) begin
                exp_ovf++;
            end else begin
                m[f].v = 1'b1; m[f].d = e[7:6]; m[f].s = e[5:3]; m[f].i = e[2]; m[f].age = 0;
            end
            m_ptr++;
            m_load_head();
        end
    endfunction

    function automatic void m_start();
        m_ptr     = 0;
        m_active  = 1'b1;
        m_started = 1'b1;
        m_load_head();
        m_spawn_ready();
    endfunction

    function automatic void m_hit(bit [1:0] dir);
        int best = -1;
        for (int k = 0; k < NS; k++) begin
            if (m[k].v && m[k].d == dir && m[k].age >= HLO && m[k].age <= HHI)
                if (best < 0 || m[k].age > m[best].age) best = k;
        end
        if (best >= 0) begin
            m_clear(best);
            exp_hit++;
        end
    endfunction

    function automatic void m_tick(bit with_hit, bit [1:0] dir);
        bit any = 1'b0;
        if (with_hit) m_hit(dir);
        for (int k = 0; k < NS; k++) begin
            if (m[k].v) begin
                if (m[k].age == LIFE - 1) begin
                    m_clear(k);
                    any = 1'b1;
                end else begin
                    m[k].age++;
                end
            end
        end
        if (any) exp_miss++;
        if (m_active && m_rem > 0) begin
            m_rem--;
            m_spawn_ready();
        end
    endfunction

    // ------------------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_slots(input string tag);
        logic [NS-1:0]   ev, ei;
        logic [2*NS-1:0] ed;
        logic [3*NS-1:0] es;
        for (int k = 0; k < NS; k++) begin
            ev[k]        = m[k].v;
            ed[2*k +: 2] = m[k].d;
            es[3*k +: 3] = m[k].s;
            ei[k]        = m[k].i;
        end
        check({tag, "/valid"}, 32'(slot_valid_out), 32'(ev));
        check({tag, "/dir"},   32'(slot_dir_out),   32'(ed));
        check({tag, "/speed"}, 32'(slot_speed_out), 32'(es));
        check({tag, "/inv"},   32'(slot_inv_out),   32'(ei));
    endtask

    task automatic check_all(input string tag);
        check_slots(tag);
        check({tag, "/busy"}, 32'(busy_out), 32'(m_active));
        check({tag, "/done"}, 32'(done_out), 32'(m_started && !m_active));
        check({tag, "/hits"}, 32'(hit_seen),  32'(exp_hit));
        check({tag, "/miss"}, 32'(miss_seen), 32'(exp_miss));
        check({tag, "/ovf"},  32'(ovf_seen),  32'(exp_ovf));
    endtask

    // ------------------------------------------------------------- stimulus
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame tick: hold the (0,0) position for 'hold' cycles, optionally with a
    // hit strobe on the first of them.
    task automatic do_tick(input bit with_hit, input bit [1:0] dir, input int hold, input int settle);
        @(negedge clk);
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        if (with_hit) begin
            bus.hit_in     = 1'b1;
            bus.hit_dir_in = dir;
        end
        @(negedge clk);
        bus.hit_in = 1'b0;
        repeat (hold - 1) @(negedge clk);
        hcount_in = 11'd5;
        vcount_in = 10'd5;
        m_tick(with_hit, dir);
        idle(settle);
    endtask

    task automatic ticks(input int n, input int settle);
        for (int t = 0; t < n; t++) do_tick(1'b0, 2'd0, 1, settle);
    endtask

    task automatic do_hit(input bit [1:0] dir, input int settle);
        @(negedge clk);
        bus.hit_in     = 1'b1;
        bus.hit_dir_in = dir;
        @(negedge clk);
        bus.hit_in = 1'b0;
        m_hit(dir);
        idle(settle);
    endtask

    task automatic do_start(input int settle);
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        m_start();
        idle(settle);
    endtask

    // One reset edge; everything must be cleared right after it.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        check({tag, "/valid"}, 32'(slot_valid_out), 32'd0);
        check({tag, "/dir"},   32'(slot_dir_out),   32'd0);
        check({tag, "/speed"}, 32'(slot_speed_out), 32'd0);
        check({tag, "/inv"},   32'(slot_inv_out),   32'd0);
        check({tag, "/busy"},  32'(busy_out),       32'd0);
        check({tag, "/done"},  32'(done_out),       32'd0);
        check({tag, "/addr"},  32'(bus.chart_addr_out), 32'd0);
        rst_in = 1'b0;
        m_reset();
    endtask

    function automatic logic [15:0] rand_note(input int delta);
        logic [1:0] d = 2'($urandom_range(0, 3));
        logic [2:0] s = 3'($urandom_range(0, 7));
        logic       i = 1'($urandom_range(0, 1));
        return {8'(delta), d, s, i, 2'b00};
    endfunction

    function automatic logic [1:0] pick_dir();
        int k = $urandom_range(0, NS - 1);
        if (m[k].v && $urandom_range(0, 3) != 0) return m[k].d;
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_in         = 1'b1;
        hcount_in      = 11'd5;
        vcount_in      = 10'd5;
        start_in       = 1'b0;
        bus.hit_in     = 1'b0;
        bus.hit_dir_in = 2'd0;
        for (int k = 0; k < DEPTH; k++) rom[k] = 16'h0002;
        m_reset();

        // Reset state
        idle(3);
        check_all("reset");
        check("reset/addr", 32'(bus.chart_addr_out), 32'd0);
        rst_in = 1'b0;
        idle(2);

        // A: delta-3 note then end; spawn after exactly 3 frames, miss after 180
        rom[0] = 16'h0340;
        rom[1] = 16'h0002;
        do_start(8);
        check_all("a_wait0");
        do_tick(1'b0, 2'd0, 1, 8);
        check_all("a_tick1");
        do_tick(1'b0, 2'd0, 3, 8);           // long (0,0) dwell still one tick
        check_all("a_tick2");
        do_tick(1'b0, 2'd0, 1, 8);
        check_all("a_tick3");
        check("a_dir0", 32'(slot_dir_out[1:0]), 32'd1);
        check("a_done", 32'(done_out), 32'd1);
        ticks(179, 2);
        check_all("a_age179");
        do_tick(1'b0, 2'd0, 1, 4);
        check_all("a_expire");
        check("a_miss", 32'(miss_seen), 32'd1);

        // B: five chord notes into four slots
        do_reset("b_rst");
        for (int k = 0; k < 5; k++) rom[k] = rand_note(0);
        rom[5] = 16'h0002;
        do_start(0);
        idle(18);
        check_slots("b_within20");
        check("b_full", 32'(slot_valid_out), 32'hF);
        idle(10);
        check_all("b_end");

        // C: hit window on a single dir-2 slot
        do_reset("c_rst");
        rom[0] = 16'h0080;
        rom[1] = 16'h0002;
        do_start(8);
        ticks(100, 2);
        do_hit(2'd2, 4);
        check_all("c_age100");
        ticks(49, 2);
        do_hit(2'd2, 4);
        check_all("c_age149");
        ticks(11, 2);
        do_hit(2'd3, 4);
        check_all("c_wrongdir");
        do_hit(2'd2, 4);
        check_all("c_age160");
        check("c_cleared", 32'(slot_valid_out), 32'd0);

        // D: oldest of two same-direction slots is taken
        do_reset("d_rst");
        rom[0] = 16'h0000;
        rom[1] = 16'h0040;
        rom[2] = 16'h0500;
        rom[3] = 16'h0002;
        do_start(12);
        ticks(170, 8);
        do_hit(2'd0, 4);
        check_all("d_oldest");
        check("d_valid", 32'(slot_valid_out), 32'h6);

        // E: hit on the expiring frame wins over the miss
        ticks(9, 4);
        do_tick(1'b1, 2'd1, 1, 6);
        check_all("e_conflict");
        check("e_valid", 32'(slot_valid_out), 32'h4);

        // F: reset while holding with three live slots, then replay
        do_reset("f_rst0");
        for (int k = 0; k < 3; k++) rom[k] = rand_note(0);
        rom[3] = rand_note(5);
        rom[4] = 16'h0002;
        do_start(20);
        ticks(2, 8);
        check_all("f_hold");
        do_reset("f_rst");
        do_start(20);
        check_all("f_replay");

        // G: chart without end marker stops after the last address
        do_reset("g_rst");
        for (int k = 0; k < DEPTH; k++) rom[k] = rand_note(0);
        do_start(1100);
        check_all("g_lastaddr");

        // H: randomized chart with mixed ticks, hits and tick+hit
        do_reset("h_rst");
        begin
            int zrun = 0;
            for (int k = 0; k < 40; k++) begin
                int dl = ($urandom_range(0, 3) == 0 && zrun < 2) ? 0 : $urandom_range(1, 20);
                zrun = (dl == 0) ? zrun + 1 : 0;
                rom[k] = rand_note(dl);
            end
        end
        rom[40] = 16'h0002;
        do_start(40);
        check_all("h_start");
        for (int op = 0; op < 600; op++) begin
            int r = $urandom_range(0, 99);
            if (r < 60)      do_tick(1'b0, 2'd0, 1, 40);
            else if (r < 80) do_tick(1'b1, pick_dir(), 1, 40);
            else             do_hit(pick_dir(), 6);
            check_all($sformatf("h_op%0d", op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
